// File: rtl/dtree_seq_ctrl.sv
// dtree_seq_ctrl -- sequential decision-tree classifier.
//
// A feature vector is accepted in IDLE and the tree held in a register
// table is walked one node per cycle using a single shared comparator.
// A leaf ends the walk with its class.  An internal node evaluated at the
// step limit ends it with an error flag.  The result is held until the
// consumer takes it.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   cfg_we     : node table write strobe (honoured only in IDLE)
//   cfg_addr   : node index to write
//   cfg_data   : node word {is_leaf, feat_idx[2:0], thr, left, right}
//   in_valid   : feature vector valid
//   in_ready   : block can accept a vector (high only in IDLE)
//   in_data    : feature i at bits [i*FW +: FW]
//   out_valid  : result valid
//   out_ready  : consumer accepts the result
//   out_class  : predicted class
//   out_err    : traversal aborted at the depth limit
//   busy       : high in any state other than IDLE
module dtree_seq_ctrl #(
    parameter int N_FEAT    = 5,
    parameter int FW        = 8,
    parameter int NODES     = 16,
    parameter int CW        = 2,
    parameter int MAX_DEPTH = 15,
    localparam int AW       = $clog2(NODES),
    localparam int DW       = 1 + 3 + FW + 2 * AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [DW-1:0]      cfg_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_FEAT*FW-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW-1:0]      out_class,
    output logic               out_err,
    output logic               busy
);

    localparam int DPW = $clog2(MAX_DEPTH + 1);
    localparam logic [DPW-1:0] DEPTH_LIMIT = DPW'(MAX_DEPTH);
    // Reset value of every table entry: a leaf whose class is 0.
    localparam logic [DW-1:0] LEAF0 = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         node_ptr_q, node_ptr_d;
    logic [DPW-1:0]        depth_q, depth_d;
    logic [N_FEAT*FW-1:0]  feat_q, feat_d;
    logic                  out_valid_q, out_valid_d;
    logic [CW-1:0]         out_class_q, out_class_d;
    logic                  out_err_q, out_err_d;
    logic [DW-1:0]         node_q [NODES];
    logic [DW-1:0]         node_d [NODES];

    // Decoded fields of the entry under evaluation.
    logic [DW-1:0]         ent_s;
    logic                  is_leaf_s;
    logic [2:0]            feat_idx_s;
    logic [FW-1:0]         thr_s;
    logic [AW-1:0]         left_s;
    logic [AW-1:0]         right_s;
    logic [FW-1:0]         feat_val_s;
    logic                  go_left_s;

    // Feature index is 3 bits wide; slots beyond N_FEAT read as zero.
    logic [FW-1:0]         feat_arr_s [8];

    for (genvar g = 0; g < 8; g++) begin : g_feat
        if (g < N_FEAT) begin : g_real
            assign feat_arr_s[g] = feat_q[g*FW +: FW];
        end else begin : g_zero
            assign feat_arr_s[g] = '0;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_err   = out_err_q;

    // Combinational table read and single shared threshold comparator.
    always_comb begin
        ent_s      = node_q[node_ptr_q];
        is_leaf_s  = ent_s[DW-1];
        feat_idx_s = ent_s[DW-2 -: 3];
        thr_s      = ent_s[2*AW +: FW];
        left_s     = ent_s[AW +: AW];
        right_s    = ent_s[0 +: AW];
        feat_val_s = feat_arr_s[feat_idx_s];
        go_left_s  = (feat_val_s <= thr_s);
    end

    // Node table next value: configuration writes land only while idle.
    always_comb begin
        node_d = node_q;
        if (cfg_we && (state_q == ST_IDLE)) begin
            node_d[cfg_addr] = cfg_data;
        end else begin
            node_d = node_q;
        end
    end

    // Controller next-state and result logic.
    always_comb begin
        state_d     = state_q;
        node_ptr_d  = node_ptr_q;
        depth_d     = depth_q;
        feat_d      = feat_q;
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        out_err_d   = out_err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    feat_d     = in_data;
                    node_ptr_d = '0;
                    depth_d    = '0;
                    state_d    = ST_WALK;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_WALK: begin
                if (is_leaf_s) begin
                    // Leaf class lives in the low bits of the left field.
                    out_class_d = left_s[CW-1:0];
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (depth_q == DEPTH_LIMIT) begin
                    out_class_d = '0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    node_ptr_d  = go_left_s ? left_s : right_s;
                    depth_d     = depth_q + DPW'(1'b1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; the table reloads leaf-class-0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            node_ptr_q  <= '0;
            depth_q     <= '0;
            feat_q      <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_err_q   <= 1'b0;
            for (int i = 0; i < NODES; i++) begin
                node_q[i] <= LEAF0;
            end
        end else begin
            state_q     <= state_d;
            node_ptr_q  <= node_ptr_d;
            depth_q     <= depth_d;
            feat_q      <= feat_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_err_q   <= out_err_d;
            node_q      <= node_d;
        end
    end

endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// Testbench for dtree_seq_ctrl: directed scenarios plus randomized tables
// and vectors, checked against a behavioural tree-walk model.
module tb_dtree_seq_ctrl;

    localparam int NF    = 5;
    localparam int FW    = 8;
    localparam int NODES = 16;
    localparam int AW    = 4;
    localparam int CW    = 2;
    localparam int MD    = 15;
    localparam int DW    = 1 + 3 + FW + 2 * AW;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [DW-1:0]      cfg_data;
    logic               in_valid;
    logic               in_ready;
    logic [NF*FW-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [CW-1:0]      out_class;
    logic               out_err;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference copy of the node table.
    logic [DW-1:0] mtbl [NODES];

    dtree_seq_ctrl #(
        .N_FEAT(NF), .FW(FW), .NODES(NODES), .CW(CW), .MAX_DEPTH(MD)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input bit leaf, input int fi, input int thr,
                                         input int l, input int r);
        logic [DW-1:0] w;
        w = {leaf, 3'(fi), 8'(thr), 4'(l), 4'(r)};
        return w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NODES; i++) mtbl[i] = mk(1'b1, 0, 0, 0, 0);
    endfunction

    // Walk the tree from the root following the rules directly.
    function automatic void model(input logic [NF*FW-1:0] x, output int cls,
                                  output int err, output int lat);
        int ptr, fi, thr, lft, rgt, fv;
        logic [DW-1:0] e;
        bit fin;
        ptr = 0; fin = 1'b0; cls = 0; err = 0; lat = 0;
        for (int d = 0; d <= MD; d++) begin
            if (!fin) begin
                e   = mtbl[ptr];
                fi  = int'(e[DW-2 -: 3]);
                thr = int'(e[2*AW +: FW]);
                lft = int'(e[AW +: AW]);
                rgt = int'(e[0 +: AW]);
                if (e[DW-1]) begin
                    cls = lft % (1 << CW); err = 0; lat = d + 1; fin = 1'b1;
                end else if (d == MD) begin
                    cls = 0; err = 1; lat = MD + 1; fin = 1'b1;
                end else begin
                    fv  = (fi < NF) ? int'(x[fi*FW +: FW]) : 0;
                    ptr = (fv <= thr) ? lft : rgt;
                end
            end
        end
    endfunction

    task automatic cfg_write(input int addr, input logic [DW-1:0] w);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = w;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mtbl[addr] = w;
    endtask

    // Send one vector, optionally with a coinciding table write, then hold
    // the result for 'hold' cycles while spurious writes are attempted.
    task automatic run_vec(input logic [NF*FW-1:0] x, input bit do_cfg, input int ca,
                           input logic [DW-1:0] cd, input int hold);
        int ecls, eerr, elat, cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = x;
        cfg_we = do_cfg; cfg_addr = AW'(ca); cfg_data = cd;
        if (do_cfg) mtbl[ca] = cd;
        model(x, ecls, eerr, elat);
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        chk("busy_walk", 32'(busy), 32'd1);
        chk("in_ready_walk", 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < MD + 5) begin
            cfg_we = 1'($urandom); cfg_addr = AW'($urandom); cfg_data = DW'($urandom);
            @(posedge clk); #1; cyc++;
        end
        cfg_we = 1'b0;
        chk("latency", 32'(cyc), 32'(elat));
        chk("out_class", 32'(out_class), 32'(ecls));
        chk("out_err", 32'(out_err), 32'(eerr));
        for (int k = 0; k < hold; k++) begin
            cfg_we = 1'($urandom); cfg_addr = AW'($urandom); cfg_data = DW'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_class", 32'(out_class), 32'(ecls));
            chk("hold_err", 32'(out_err), 32'(eerr));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        cfg_we = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
    endtask

    function automatic logic [NF*FW-1:0] rand_vec();
        logic [NF*FW-1:0] v;
        for (int i = 0; i < NF; i++) v[i*FW +: FW] = FW'($urandom);
        return v;
    endfunction

    initial begin
        logic [NF*FW-1:0] v;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_class", 32'(out_class), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);

        // Unconfigured table: root leaf, class 0, one cycle.
        run_vec(rand_vec(), 1'b0, 0, '0, 0);

        // Root split on f0 <= 5; leaf entries carry junk in unused fields.
        cfg_write(0, mk(1'b0, 0, 5, 1, 2));
        cfg_write(1, mk(1'b1, 6, 8'hAA, 3, 9));
        cfg_write(2, mk(1'b1, 2, 8'h55, 1, 15));
        v = rand_vec(); v[FW-1:0] = 8'd5;
        run_vec(v, 1'b0, 0, '0, 1);
        v = rand_vec(); v[FW-1:0] = 8'd6;
        run_vec(v, 1'b0, 0, '0, 2);

        // Self loop at the root: abort at the step limit; long hold with
        // writes attempted, then table must be unchanged.
        cfg_write(0, mk(1'b0, 0, 0, 0, 0));
        v = rand_vec(); v[FW-1:0] = 8'd0;
        run_vec(v, 1'b0, 0, '0, 10);
        run_vec(v, 1'b0, 0, '0, 0);

        // Out-of-range feature index reads 0, so thr=0 always goes left.
        cfg_write(0, mk(1'b0, 7, 0, 1, 2));
        cfg_write(1, mk(1'b1, 0, 0, 2, 0));
        cfg_write(2, mk(1'b1, 0, 0, 3, 0));
        for (int i = 0; i < 3; i++) run_vec(rand_vec(), 1'b0, 0, '0, $urandom_range(0, 2));
        cfg_write(0, mk(1'b0, 5, 0, 1, 2));
        run_vec(rand_vec(), 1'b0, 0, '0, 0);

        // Reset in mid-walk, with inputs and a write competing with reset.
        cfg_write(0, mk(1'b0, 0, 0, 0, 0));
        in_valid = 1'b1; in_data = '0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("walk_no_valid", 32'(out_valid), 32'd0);
        end
        rst = 1'b1; in_valid = 1'b1; cfg_we = 1'b1; cfg_addr = '0;
        cfg_data = mk(1'b1, 0, 0, 3, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
        model_reset();
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        run_vec(rand_vec(), 1'b0, 0, '0, 0);

        // Random tables, random vectors, some coinciding writes.
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < NODES; n++) begin
                cfg_write(n, mk(($urandom_range(0, 9) < 4), $urandom_range(0, 7),
                                $urandom_range(0, 255), $urandom_range(0, 15),
                                $urandom_range(0, 15)));
            end
            for (int k = 0; k < 12; k++) begin
                run_vec(rand_vec(), ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
                        mk(($urandom_range(0, 1) == 1), $urandom_range(0, 7),
                           $urandom_range(0, 255), $urandom_range(0, 15),
                           $urandom_range(0, 15)),
                        $urandom_range(0, 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dtree_seq_ctrl.md
DTREE_SEQ_CTRL -- requirements
Module: dtree_seq_ctrl

Interface
REQ-001 SHALL have parameter N_FEAT, default 5: number of input features.
REQ-002 SHALL have parameter FW, default 8: feature and threshold width.
REQ-003 SHALL have parameter NODES, default 16: node table depth; AW = clog2(NODES).
REQ-004 SHALL have parameter CW, default 2: class width.
REQ-005 SHALL have parameter MAX_DEPTH, default 15: traversal step limit.
REQ-006 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port cfg_we, input, 1: node table write strobe.
REQ-009 SHALL have port cfg_addr, input, AW: node index to write.
REQ-010 SHALL have port cfg_data, input, 1+3+FW+2*AW: node word {is_leaf, feat_idx[2:0], thr[FW-1:0], left[AW-1:0], right[AW-1:0]}.
REQ-011 SHALL have port in_valid, input, 1: feature vector valid.
REQ-012 SHALL have port in_ready, output, 1: block can accept a vector.
REQ-013 SHALL have port in_data, input, N_FEAT*FW: feature i at bits [i*FW +: FW].
REQ-014 SHALL have port out_valid, output, 1: result valid.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-016 SHALL have port out_class, output, CW: predicted class.
REQ-017 SHALL have port out_err, output, 1: traversal aborted at depth limit.
REQ-018 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-019 SHALL implement an FSM with states IDLE, WALK and DONE.
REQ-020 SHALL assert in_ready only in IDLE; a transfer occurs when in_valid and in_ready are both high at a clock edge.
REQ-021 SHALL, on transfer, register all of in_data, set node_ptr=0 and depth=0, and go to WALK.
REQ-022 SHALL, in WALK, evaluate the table entry node[node_ptr] once per cycle (combinational read of the register table, one comparator shared by all nodes).
REQ-023 SHALL, for a leaf entry, load out_class = left[CW-1:0], set out_err=0, assert out_valid and go to DONE.
REQ-024 SHALL, for an internal entry, set node_ptr=left if feature[feat_idx] <= thr (unsigned, inclusive), else node_ptr=right, and increment depth.
REQ-025 SHALL use feature value 0 when feat_idx >= N_FEAT.
REQ-026 SHALL, when an internal node is evaluated with depth == MAX_DEPTH, set out_class=0, out_err=1, assert out_valid and go to DONE.
REQ-027 SHALL give a latency of d+1 cycles from the accepting edge to the out_valid assertion for a leaf at depth d (root = depth 0), and MAX_DEPTH+1 cycles for an aborted traversal.
REQ-028 SHALL, in DONE, hold out_valid, out_class and out_err stable until out_ready is high at an edge, then clear out_valid and return to IDLE.
REQ-029 SHALL NOT accept input in the cycle DONE completes; the next acceptance is possible at the following edge at the earliest.
REQ-030 SHALL apply cfg_we writes only in IDLE; writes in WALK or DONE SHALL be ignored.
REQ-031 SHALL, when cfg_we and an input transfer coincide in IDLE, perform both; the new entry SHALL be visible to the walk that starts.
REQ-032 SHALL ignore cfg_data bits unused by the entry type (thr and right on leaves).

Reset
REQ-033 SHALL, with rst high at an edge, enter IDLE and clear out_valid, out_class, out_err, busy, node_ptr and depth.
REQ-034 SHALL reset every table entry to a leaf with class 0 (is_leaf=1, all other fields 0).
REQ-035 SHALL let rst in WALK or DONE abandon the evaluation with no out_valid pulse; rst SHALL take priority over cfg_we and in_valid.

Verification
REQ-036 SHALL cover: reset, then a vector with no configuration -> out_valid 1 cycle after accept, out_class=0, out_err=0.
REQ-037 SHALL cover: node0={0,f0,thr=5,L=1,R=2}, node1=leaf 3, node2=leaf 1; X0=5 -> class 3; X0=6 -> class 1; each result 2 cycles after accept.
REQ-038 SHALL cover: node0={0,f0,thr=0,L=0,R=0}, X0=0 -> out_err=1, out_class=0, MAX_DEPTH+1=16 cycles after accept.
REQ-039 SHALL cover: out_ready held low for 10 cycles -> out_class stable and in_ready=0; cfg_we issued in that window -> table unchanged.
REQ-040 SHALL cover: rst asserted mid-WALK -> no out_valid, in_ready=1 on the next cycle, table back to leaf-class-0.
REQ-041 SHALL cover: feat_idx=7 with thr=0 -> left branch taken for any input vector.
